// File: rtl/qpi_pkg.sv
// Shared defaults and grant-source encoding for the QPI memory arbiter.
package qpi_pkg;

  localparam int QPI_ADDR_W = 8;
  localparam int QPI_DATA_W = 8;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    QW   = 2'd1,
    QR   = 2'd2,
    INT  = 2'd3
  } grant_src_e;

endpackage

// File: rtl/qpi_req_slot.sv
// One-deep capture slot for a QPI request pulse, with a sticky overrun flag.
module qpi_req_slot
  import qpi_pkg::*;
#(
  parameter int PAYLOAD_W = QPI_ADDR_W + QPI_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flag,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic                 i_issue,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_overrun
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_overrun;

  // A new pulse always takes the slot; it only loses a request if the old entry was not issued this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_flag) begin
        r_valid   <= 1'b1;
        r_payload <= i_payload;
        if (r_valid && !i_issue) begin
          r_overrun <= 1'b1;
        end
      end else if (i_issue) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/qpi_mem_arbiter.sv
// Single-port RAM arbiter between a QPI slave (write/read slots) and an internal requester.
module qpi_mem_arbiter
  import qpi_pkg::*;
#(
  parameter int ADDR_W   = QPI_ADDR_W,
  parameter int DATA_W   = QPI_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              main_clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] q_addr,
  input  logic [DATA_W-1:0] q_write_data,
  input  logic              q_write_flag,
  input  logic              q_read_flag,
  output logic [DATA_W-1:0] q_read_data,
  output logic              q_overrun,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  grant_src_e w_src;
  logic                     w_starve;
  logic                     w_qw_valid;
  logic [ADDR_W+DATA_W-1:0] w_qw_payload;
  logic [ADDR_W-1:0]        w_qw_addr;
  logic [DATA_W-1:0]        w_qw_data;
  logic                     w_qw_overrun;
  logic                     w_qr_valid;
  logic [ADDR_W-1:0]        w_qr_addr;
  logic                     w_qr_overrun;

  logic [WAIT_W-1:0] r_wait;
  logic              r_qr_inflight;
  logic              r_int_inflight;
  logic [DATA_W-1:0] r_qrd_hold;

  qpi_req_slot #(
    .PAYLOAD_W(ADDR_W + DATA_W)
  ) u_qw_slot (
    .i_clk     (main_clock),
    .i_rst_n   (reset_n),
    .i_flag    (q_write_flag),
    .i_payload ({q_addr, q_write_data}),
    .i_issue   (w_src == QW),
    .o_valid   (w_qw_valid),
    .o_payload (w_qw_payload),
    .o_overrun (w_qw_overrun)
  );

  qpi_req_slot #(
    .PAYLOAD_W(ADDR_W)
  ) u_qr_slot (
    .i_clk     (main_clock),
    .i_rst_n   (reset_n),
    .i_flag    (q_read_flag),
    .i_payload (q_addr),
    .i_issue   (w_src == QR),
    .o_valid   (w_qr_valid),
    .o_payload (w_qr_addr),
    .o_overrun (w_qr_overrun)
  );

  assign w_qw_addr = w_qw_payload[ADDR_W+DATA_W-1:DATA_W];
  assign w_qw_data = w_qw_payload[DATA_W-1:0];
  assign w_starve  = i_req && (r_wait >= WAIT_LIMIT);

  // Gating on reset_n keeps mem_en and i_grant low while reset is held, even with i_req high.
  always_comb begin
    w_src = NONE;
    if (reset_n) begin
      if (w_starve) begin
        w_src = INT;
      end else if (w_qw_valid) begin
        w_src = QW;
      end else if (w_qr_valid) begin
        w_src = QR;
      end else if (i_req) begin
        w_src = INT;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_src)
      QW: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_qw_addr;
        mem_wdata = w_qw_data;
      end
      QR: begin
        mem_en   = 1'b1;
        mem_addr = w_qr_addr;
      end
      INT: begin
        mem_en    = 1'b1;
        mem_we    = i_we;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
      end
      default: begin
      end
    endcase
  end

  assign i_grant = (w_src == INT);

  // A dropped request also restarts the count, so a later request starts fresh.
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (!i_req || i_grant) begin
      r_wait <= '0;
    end else if (r_wait < WAIT_LIMIT) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_qr_inflight  <= 1'b0;
      r_int_inflight <= 1'b0;
      r_qrd_hold     <= '0;
    end else begin
      r_qr_inflight  <= (w_src == QR);
      r_int_inflight <= (w_src == INT) && !i_we;
      if (r_qr_inflight) begin
        r_qrd_hold <= mem_rdata;
      end
    end
  end

  // Read data is forwarded straight from the RAM in the return cycle, then held.
  assign q_read_data = r_qr_inflight ? mem_rdata : r_qrd_hold;
  assign q_overrun   = w_qw_overrun | w_qr_overrun;
  assign i_rvalid    = r_int_inflight;
  assign i_rdata     = r_int_inflight ? mem_rdata : '0;

endmodule
